costas_nco: RTL

Numerically controlled oscillator closing the Costas carrier-recovery loop. Consumes the 24-bit phase control word `pd` from the loop filter and a fixed centre-frequency word. Accumulates phase and produces quadrature local-carrier samples (sin/cos) for the I/Q mixers. Pipelined, one sample per enabled clock, quarter-wave ROM lookup.

---
 rtl/costas_pkg.sv | 17 +
 rtl/costas_nco_if.sv | 15 +
 rtl/nco_quarter_rom.sv | 55 +++++
 rtl/costas_nco.sv | 107 ++++++++++
 4 files changed

// File: rtl/costas_pkg.sv
// Shared constants and types for the Costas-loop NCO.
// The LFSR constants are used only when COSTAS_NCO_DITHER_EN is defined.
package costas_pkg;
  localparam int PCW_W      = 24;
  localparam int NCO_ADDR_W = 10;
  localparam int NCO_OUT_W  = 16;

  typedef logic [1:0] quad_t;

  // Fibonacci x^16+x^14+x^13+x^11+1, right-shifting form: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction
endpackage

// File: rtl/costas_nco_if.sv
// Sample-side bus of the NCO: control words and strobe in, quadrature carrier out.
interface costas_nco_if #(
  parameter int PCW_W = costas_pkg::PCW_W,
  parameter int OUT_W = costas_pkg::NCO_OUT_W
);
  logic                    en;
  logic [PCW_W-1:0]        freq_word;
  logic [PCW_W-1:0]        pd;
  logic signed [OUT_W-1:0] sin_out;
  logic signed [OUT_W-1:0] cos_out;
  logic                    out_valid;

  modport master (output en, freq_word, pd, input sin_out, cos_out, out_valid);
  modport slave  (input en, freq_word, pd, output sin_out, cos_out, out_valid);
endinterface

// File: rtl/nco_quarter_rom.sv
// Dual-read registered quarter-wave sine ROM; entries sit at half-sample offsets
// so that mirroring into the other quadrants is exact.
module nco_quarter_rom #(
  parameter int IDX_W = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] addr_a,
  input  logic [IDX_W-1:0] addr_b,
  output logic [OUT_W-1:0] data_a,
  output logic [OUT_W-1:0] data_b
);
  localparam int DEPTH = 1 << IDX_W;

  // Taylor series keeps table generation inside plain real arithmetic
  function automatic logic [OUT_W-1:0] rom_val(input int k);
    real x, term, acc;
    x    = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / real'(DEPTH * 4);
    term = x;
    acc  = x;
    for (int n = 1; n < 14; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      acc  = acc + term;
    end
    return OUT_W'($rtoi(acc * real'((2 ** (OUT_W - 1)) - 1) + 0.5));
  endfunction

  logic [OUT_W-1:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam logic [OUT_W-1:0] VAL = rom_val(k);
    assign rom[k] = VAL;
  end

  logic [OUT_W-1:0] data_a_q, data_a_d, data_b_q, data_b_d;

  always_comb begin
    data_a_d = rom[addr_a];
    data_b_d = rom[addr_b];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  assign data_a = data_a_q;
  assign data_b = data_b_q;
endmodule

// File: rtl/costas_nco.sv
// Costas-loop NCO: phase accumulator -> quadrant/index -> quarter ROM -> sign.
// Optional phase dither before truncation when COSTAS_NCO_DITHER_EN is defined.
module costas_nco #(
  parameter int PCW_W  = costas_pkg::PCW_W,
  parameter int ADDR_W = costas_pkg::NCO_ADDR_W,
  parameter int OUT_W  = costas_pkg::NCO_OUT_W
) (
  input logic          clk,
  input logic          rst,
  costas_nco_if.slave  bus
);
  import costas_pkg::*;

  localparam int IDX_W  = ADDR_W - 2;
  localparam int STAGES = 3;

  logic [PCW_W-1:0]  phase_acc_q, phase_acc_d;
  logic [ADDR_W-1:0] addr_sin, addr_cos;
  quad_t             sin_quad_q, sin_quad_d, cos_quad_q, cos_quad_d;
  logic [IDX_W-1:0]  sin_idx_q, sin_idx_d, cos_idx_q, cos_idx_d;
  logic [IDX_W-1:0]  rom_idx_sin, rom_idx_cos;
  logic [OUT_W-1:0]  rom_sin, rom_cos;
  logic              sin_neg_q, sin_neg_d, cos_neg_q, cos_neg_d;
  logic [OUT_W-1:0]  sin_out_q, sin_out_d, cos_out_q, cos_out_d;
  logic [STAGES:0]   vld_pipe_q, vld_pipe_d;

`ifdef COSTAS_NCO_DITHER_EN
  logic [15:0]      lfsr_q, lfsr_d;
  logic [PCW_W-1:0] dith_w, phase_dith;

  always_comb begin
    lfsr_d = bus.en ? lfsr_next(lfsr_q) : lfsr_q;
    dith_w = '0;
    for (int b = 0; b < PCW_W - ADDR_W; b++)
      if (b < 16) dith_w[b] = lfsr_q[b];
    phase_dith = phase_acc_q + dith_w;
    addr_sin   = phase_dith[PCW_W-1 -: ADDR_W];
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end
`else
  always_comb addr_sin = phase_acc_q[PCW_W-1 -: ADDR_W];
`endif

  always_comb begin
    phase_acc_d = phase_acc_q;
    if (bus.en) phase_acc_d = phase_acc_q + bus.freq_word + bus.pd;

    addr_cos   = addr_sin + ADDR_W'(2 ** (ADDR_W - 2));
    sin_quad_d = addr_sin[ADDR_W-1 -: 2];
    sin_idx_d  = addr_sin[IDX_W-1:0];
    cos_quad_d = addr_cos[ADDR_W-1 -: 2];
    cos_idx_d  = addr_cos[IDX_W-1:0];

    // odd quadrants walk the quarter table backwards
    rom_idx_sin = sin_quad_q[0] ? ~sin_idx_q : sin_idx_q;
    rom_idx_cos = cos_quad_q[0] ? ~cos_idx_q : cos_idx_q;
    sin_neg_d   = sin_quad_q[1];
    cos_neg_d   = cos_quad_q[1];

    sin_out_d  = sin_neg_q ? -rom_sin : rom_sin;
    cos_out_d  = cos_neg_q ? -rom_cos : rom_cos;
    vld_pipe_d = {vld_pipe_q[STAGES-1:0], bus.en};
  end

  nco_quarter_rom #(.IDX_W(IDX_W), .OUT_W(OUT_W)) u_rom (
    .clk    (clk),
    .rst    (rst),
    .addr_a (rom_idx_sin),
    .addr_b (rom_idx_cos),
    .data_a (rom_sin),
    .data_b (rom_cos)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_acc_q <= '0;
      sin_quad_q  <= '0;
      sin_idx_q   <= '0;
      cos_quad_q  <= '0;
      cos_idx_q   <= '0;
      sin_neg_q   <= 1'b0;
      cos_neg_q   <= 1'b0;
      sin_out_q   <= '0;
      cos_out_q   <= '0;
      vld_pipe_q  <= '0;
    end else begin
      phase_acc_q <= phase_acc_d;
      sin_quad_q  <= sin_quad_d;
      sin_idx_q   <= sin_idx_d;
      cos_quad_q  <= cos_quad_d;
      cos_idx_q   <= cos_idx_d;
      sin_neg_q   <= sin_neg_d;
      cos_neg_q   <= cos_neg_d;
      sin_out_q   <= sin_out_d;
      cos_out_q   <= cos_out_d;
      vld_pipe_q  <= vld_pipe_d;
    end
  end

  assign bus.sin_out   = sin_out_q;
  assign bus.cos_out   = cos_out_q;
  assign bus.out_valid = vld_pipe_q[STAGES];
endmodule
